instr_encode: RTL

Instruction-word encoder: the inverse of the core's immediate extender. It packs register fields and a 32-bit immediate into a RISC-V RV32I instruction word for formats I/S/B/J/U, and expands an `li rd, imm32` pseudo-op into one or two real instructions. It feeds the debug program-buffer / instruction-injection path through a registered valid/ready stream, flagging any immediate that the selected format cannot represent.

---
 rtl/instr_encode_if.sv | 33 +++
 rtl/instr_encode.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_if.sv
// Request/response stream between an instruction-injection source and the instr_encode block.
interface instr_encode_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_li;
   logic [2:0]           in_imm_sel;
   logic [6:0]           in_opcode;
   logic [4:0]           in_rd;
   logic [2:0]           in_funct3;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [31:0]          in_imm;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic                 out_err;
   logic                 out_last;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output in_valid, in_li, in_imm_sel, in_opcode, in_rd, in_funct3,
             in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_last, err_cnt
   );

   modport slave (
      input  in_valid, in_li, in_imm_sel, in_opcode, in_rd, in_funct3,
             in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_last, err_cnt
   );
endinterface

// File: rtl/instr_encode.sv
// RV32I I/S/B/J/U word packer plus li expansion; range checks built only with KV_IMM_RANGE_CHECK_EN.
// Latency: one cycle from accept to output; a 2-word li occupies two output cycles.
// Backpressure: output held stable while !out_ready; in_ready low while word 2 of an li is pending.
module instr_encode #(
   parameter int ERR_CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   instr_encode_if.slave bus
);
   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP_LUI = 7'h37;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_HOLD,
      ST_HOLD_FIRST
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] word2_q, word2_d;
   logic        valid_q, valid_d;
   logic        last_q,  last_d;
   logic        err_q,   err_d;

   logic [31:0] imm;
   logic [4:0]  rd;
   logic [6:0]  op;
   logic [31:0] fmt_word;
   logic [31:0] li_w1;
   logic [31:0] li_w2;
   logic        li_two;
   logic        imm_fits12;
   logic [19:0] li_hi;
   logic        req_err;
   logic        in_ready;
   logic        accept;

   assign imm = bus.in_imm;
   assign rd  = bus.in_rd;
   assign op  = bus.in_opcode;

   assign imm_fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);

   always_comb begin
      fmt_word = '0;
      if (bus.in_imm_sel[2]) begin
         fmt_word = {imm[31:12], rd, op};
      end else begin
         unique case (bus.in_imm_sel[1:0])
            2'b00:   fmt_word = {imm[11:0], bus.in_rs1, bus.in_funct3, rd, op};
            2'b01:   fmt_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                 imm[4:0], op};
            2'b10:   fmt_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                                 bus.in_funct3, imm[4:1], imm[11], op};
            default: fmt_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         endcase
      end
   end

   // The ADDI adds a sign-extended lo, so the LUI half must pre-compensate with +imm[11].
   assign li_hi = imm[31:12] + {19'd0, imm[11]};
   assign li_w2 = {imm[11:0], rd, 3'b000, rd, OP_IMM};

   always_comb begin
      li_two = 1'b0;
      if (imm_fits12) begin
         li_w1 = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
      end else if (imm[11:0] == '0) begin
         li_w1 = {imm[31:12], rd, OP_LUI};
      end else begin
         li_w1  = {li_hi, rd, OP_LUI};
         li_two = 1'b1;
      end
   end

`ifdef KV_IMM_RANGE_CHECK_EN
   logic fmt_bad;

   always_comb begin
      fmt_bad = 1'b0;
      if (bus.in_imm_sel[2]) begin
         fmt_bad = (imm[11:0] != '0);
      end else begin
         unique case (bus.in_imm_sel[1:0])
            2'b00, 2'b01: fmt_bad = !imm_fits12;
            2'b10:   fmt_bad = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
            default: fmt_bad = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
         endcase
      end
   end

   assign req_err = !bus.in_li && fmt_bad;
`else
   assign req_err = 1'b0;
`endif

   assign in_ready = (state_q == ST_EMPTY) || ((state_q == ST_HOLD) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      word2_d = word2_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = err_q;
      unique case (state_q)
         ST_EMPTY, ST_HOLD: begin
            if (accept) begin
               valid_d = 1'b1;
               err_d   = req_err;
               word2_d = li_w2;
               if (bus.in_li) begin
                  instr_d = li_w1;
                  last_d  = !li_two;
                  state_d = li_two ? ST_HOLD_FIRST : ST_HOLD;
               end else begin
                  instr_d = fmt_word;
                  last_d  = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if ((state_q == ST_HOLD) && bus.out_ready) begin
               valid_d = 1'b0;
               state_d = ST_EMPTY;
            end
         end
         ST_HOLD_FIRST: begin
            if (bus.out_ready) begin
               instr_d = word2_q;
               last_d  = 1'b1;
               err_d   = 1'b0;
               state_d = ST_HOLD;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         instr_q <= '0;
         word2_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         word2_q <= word2_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

`ifdef KV_IMM_RANGE_CHECK_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && req_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = '0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_instr = instr_q;
   assign bus.out_err   = err_q;
   assign bus.out_last  = last_q;
endmodule
